// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter.
// Arbiter FSM states and index width helper.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    ACK,
    NEXT
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker for the UART TX arbiter.
// One-hot pick of first request at or above the pointer.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic               o_valid
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_rot_pick;
  logic [2*NUM_REQ-1:0] w_back;

  // Rotate so the pointer sits at bit 0, take lowest set, rotate back.
  always_comb begin
    w_dbl      = {i_req, i_req} >> i_ptr;
    w_rot      = w_dbl[NUM_REQ-1:0];
    w_rot_pick = w_rot & (~w_rot + NUM_REQ'(1));
    w_back     = {w_rot_pick, w_rot_pick} << i_ptr;
    o_pick     = w_back[2*NUM_REQ-1:NUM_REQ];
    o_valid    = |i_req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ requesters.
// Round-robin with frame lock and start-timeout detection.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 err_timeout
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(START_TIMEOUT - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [IW-1:0]      r_ptr, w_ptr_nxt;
  logic [IW-1:0]      r_owner, w_owner_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic               r_last, w_last_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_err, w_err_nxt;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_pick_vld;
  logic [IW-1:0]      w_pick_idx;
  logic [IW-1:0]      w_owner_inc;
  logic [CW-1:0]      w_cnt_inc;
  logic [7:0]         w_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

  // One-hot pick to owner index.
  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_pick[k]) w_pick_idx = IW'(k);
  end

  assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + IW'(1);
  assign w_cnt_inc   = r_cnt + CW'(1);

  // Next-state and next registered outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_grant_nxt    = r_grant;
    w_ack_nxt      = '0;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_last_nxt     = r_last;
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!tx_busy && w_pick_vld) begin
          w_owner_nxt    = w_pick_idx;
          w_grant_nxt    = w_pick;
          w_tx_data_nxt  = w_bytes[w_pick_idx];
          w_last_nxt     = req_last[w_pick_idx];
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (w_cnt_inc == TO_LIM) begin
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_ack_nxt   = r_grant;
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        if (r_last) begin
          w_grant_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (req[r_owner]) begin
          w_tx_data_nxt  = w_bytes[r_owner];
          w_last_nxt     = req_last[r_owner];
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = ISSUE;
        end else begin
          w_grant_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_grant    <= w_grant_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign ack         = r_ack;
  assign grant       = r_grant;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter.
// Busy-model transmitter plus hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .START_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .ack         (ack),
    .grant       (grant),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises 2 cycles after start, lasts m_bl.
  int m_cnt;
  int m_bl = 100;
  bit m_en = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 0;
    else if (tx_start && m_en) m_cnt <= m_bl + 1;
    else if (m_cnt > 0) m_cnt <= m_cnt - 1;
  end
  assign tx_busy = (m_cnt > 0) && (m_cnt <= m_bl);

  // Event log sampled on the falling edge.
  int st_cyc[$];
  int fall_cyc[$];
  int ack_cyc[$];
  int err_cyc[$];
  bit busy_q = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) st_cyc.push_back(cyc);
      if (ack != '0) ack_cyc.push_back(cyc);
      if (err_timeout) err_cyc.push_back(cyc);
      if (busy_q && !tx_busy) fall_cyc.push_back(cyc);
    end
    busy_q = tx_busy;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input int kind, input int idx);
    case (kind)
      0:       return tx_start;
      1:       return ack[idx];
      2:       return err_timeout;
      default: return tx_busy;
    endcase
  endfunction

  // kind: 0 tx_start, 1 ack[idx], 2 err_timeout, 3 tx_busy
  task automatic wait_for(input string tag, input int kind,
                          input int idx, input int budget);
    int n;
    n = 0;
    while (!hit(kind, idx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(hit(kind, idx)), 32'd1);
  endtask

  task automatic set_req(input int i, input logic [7:0] d,
                         input logic l);
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
    req[i]             = 1'b1;
  endtask

  task automatic clr_logs();
    st_cyc.delete();
    fall_cyc.delete();
    ack_cyc.delete();
    err_cyc.delete();
  endtask

  int t0, s, a, e;
  int rr_exp[5] = '{0, 1, 3, 0, 1};

  initial begin
    req      = '0;
    req_data = '0;
    req_last = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_start", tx_start, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err_timeout, 0);
    check("rst_data", tx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_grant", grant, 0);

    // single byte from requester 2
    clr_logs();
    m_bl = 100;
    set_req(2, 8'hA5, 1'b1);
    t0 = cyc;
    wait_for("s1_wait_start", 0, 0, 20);
    s = cyc;
    check("s1_latency", s - t0, 1);
    check("s1_data", tx_data, 8'hA5);
    check("s1_grant", grant, 4'b0100);
    @(negedge clk);
    check("s1_start_pulse", tx_start, 0);
    wait_for("s1_wait_ack", 1, 2, 400);
    a = cyc;
    req[2] = 1'b0;
    check("s1_ack", ack, 4'b0100);
    check("s1_ack_delay", a - ((fall_cyc.size() > 0) ? fall_cyc[0] : 0), 1);
    @(negedge clk);
    check("s1_ack_pulse", ack, 0);
    check("s1_grant_clr", grant, 0);

    // reset in the middle of a byte
    set_req(1, 8'h77, 1'b1);
    wait_for("r_wait_start", 0, 0, 20);
    check("r_grant", grant, 4'b0010);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("r_grant_clr", grant, 0);
    check("r_start_clr", tx_start, 0);
    check("r_ack_clr", ack, 0);
    check("r_err_clr", err_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_bl  = 5;
    set_req(0, 8'h01, 1'b1);
    set_req(3, 8'h03, 1'b1);
    wait_for("r_wait_s0", 0, 0, 20);
    check("r_fresh_grant", grant, 4'b0001);
    check("r_fresh_data", tx_data, 8'h01);
    wait_for("r_wait_a0", 1, 0, 100);
    req[0] = 1'b0;
    wait_for("r_wait_s3", 0, 0, 20);
    check("r_next_grant", grant, 4'b1000);
    wait_for("r_wait_a3", 1, 3, 100);
    req[3] = 1'b0;
    repeat (3) @(negedge clk);

    // round robin over requesters 0,1,3
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h20 + i);
    req_last = 4'b1111;
    req      = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      wait_for("rr_wait_start", 0, 0, 30);
      check($sformatf("rr_grant%0d", k), grant, 32'(1) << rr_exp[k]);
      check($sformatf("rr_data%0d", k), tx_data, 32'h20 + rr_exp[k]);
      wait_for("rr_wait_ack", 1, rr_exp[k], 100);
    end
    req = '0;
    repeat (4) @(negedge clk);
    check("rr_idle", grant, 0);

    // transmitter never starts, then next requester served
    clr_logs();
    m_en = 1'b0;
    set_req(2, 8'h3C, 1'b1);
    set_req(3, 8'hC3, 1'b1);
    wait_for("to_wait_start", 0, 0, 20);
    s = cyc;
    check("to_grant", grant, 4'b0100);
    wait_for("to_wait_err", 2, 0, 40);
    e = cyc;
    check("to_delay", e - s, 16);
    check("to_grant_clr", grant, 0);
    check("to_no_ack", ack_cyc.size(), 0);
    m_en   = 1'b1;
    req[2] = 1'b0;
    wait_for("to_wait_next", 0, 0, 20);
    check("to_next_grant", grant, 4'b1000);
    check("to_next_data", tx_data, 8'hC3);
    wait_for("to_wait_ack", 1, 3, 100);
    req[3] = 1'b0;
    @(negedge clk);
    check("to_err_count", err_cyc.size(), 1);

    // requester 3 drops req while its byte is in flight
    clr_logs();
    set_req(3, 8'h5A, 1'b0);
    wait_for("dr_wait_start", 0, 0, 20);
    check("dr_grant", grant, 4'b1000);
    wait_for("dr_wait_busy", 3, 0, 20);
    repeat (2) @(negedge clk);
    req[3] = 1'b0;
    wait_for("dr_wait_ack", 1, 3, 100);
    check("dr_ack", ack, 4'b1000);
    @(negedge clk);
    check("dr_grant_next", grant, 4'b1000);
    @(negedge clk);
    check("dr_grant_clr", grant, 0);
    repeat (10) @(negedge clk);
    check("dr_one_start", st_cyc.size(), 1);

    // 3-byte locked frame from 1 while 0 waits
    clr_logs();
    set_req(1, 8'h10, 1'b0);
    wait_for("fl_wait_s0", 0, 0, 20);
    check("fl_grant0", grant, 4'b0010);
    check("fl_data0", tx_data, 8'h10);
    set_req(0, 8'h99, 1'b1);
    wait_for("fl_wait_a0", 1, 1, 100);
    set_req(1, 8'h11, 1'b0);
    wait_for("fl_wait_s1", 0, 0, 20);
    check("fl_grant1", grant, 4'b0010);
    check("fl_data1", tx_data, 8'h11);
    wait_for("fl_wait_a1", 1, 1, 100);
    set_req(1, 8'h12, 1'b1);
    wait_for("fl_wait_s2", 0, 0, 20);
    check("fl_grant2", grant, 4'b0010);
    check("fl_data2", tx_data, 8'h12);
    wait_for("fl_wait_a2", 1, 1, 100);
    req[1] = 1'b0;
    wait_for("fl_wait_s3", 0, 0, 20);
    check("fl_grant_req0", grant, 4'b0001);
    check("fl_data_req0", tx_data, 8'h99);
    wait_for("fl_wait_a3", 1, 0, 100);
    req[0] = 1'b0;
    @(negedge clk);
    if (st_cyc.size() >= 3 && fall_cyc.size() >= 2) begin
      check("fl_gap1", st_cyc[1] - fall_cyc[0], 3);
      check("fl_gap2", st_cyc[2] - fall_cyc[1], 3);
    end else begin
      check("fl_log_size", st_cyc.size(), 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter among NUM_REQ requesters, using round-robin arbitration with frame locking.
- Accepts byte requests with a req/ack handshake and sequences the transmitter through a tx_start pulse and tx_busy status.
- Detects a transmitter that fails to start.
- Sits between on-chip byte producers (status reporter, command responder, debug echo) and the single TX serializer/baud engine paired with our UART receiver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 16, cycles allowed after tx_start for tx_busy to rise before declaring a fault.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester byte request, level.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is final byte of requester's frame.
- ack  out  NUM_REQ  one-cycle pulse: requester's byte fully transmitted.
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_data  out  8  byte to transmitter; stable from tx_start until ack.
- tx_busy  in  1  transmitter busy (high from shortly after tx_start through stop bit).
- err_timeout  out  1  one-cycle pulse: tx_busy never rose.

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = 0; latched last = 0; timeout counter = 0. Reset mid-transfer aborts immediately with no ack.
- Registered outputs only. Requester i holds req[i], its data and its last stable until ack[i] or grant loss.
- IDLE:
  - Wait while tx_busy=1 or req=0.
  - Otherwise pick the first asserted req at or above the rr pointer, wrapping modulo NUM_REQ.
  - Next edge: grant owner, latch tx_data/last, go ISSUE.
  - Latency: req sampled at cycle t gives tx_start high at t+1.
- ISSUE: tx_start=1 for exactly one cycle; clear counter; go WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1: go WAIT_DONE.
  - Otherwise increment counter. When counter reaches START_TIMEOUT-1: pulse err_timeout, no ack, clear grant, set pointer = owner+1, go IDLE.
- WAIT_DONE: tx_busy sampled 0 means go ACK.
- ACK:
  - ack[owner]=1 for this cycle only.
  - If latched last=1: clear grant, set pointer = owner+1 (wrap), go IDLE.
  - Otherwise go NEXT.
- NEXT (cycle after ack): requester has updated data/last or dropped req.
  - req[owner]=1: latch new data/last, go ISSUE with grant held (frame lock).
  - Otherwise clear grant, advance pointer, go IDLE.
- Inter-byte gap within a locked frame: tx_busy low at t gives tx_start at t+3.
- req[owner] dropped during WAIT_*: the byte in flight completes, ack still pulses, and the grant is released at NEXT.
- Non-owner req changes are ignored until IDLE. A new req arriving in the same cycle as ack is arbitrated on the next IDLE.
- Pointer wraps from NUM_REQ-1 to 0. With a single active requester, it is re-granted each time.
- Counter width: $clog2(START_TIMEOUT+1).

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK, NEXT);
  - function to compute owner index width from NUM_REQ.
- Sub-module uart_rr_pick: combinational round-robin picker (req vector, pointer), producing a one-hot pick and a valid flag.

Test Plan:
- Single byte: req[2]=1, data 8'hA5, last=1 → tx_start one cycle later with tx_data=8'hA5, grant=4'b0100; bus model busy 100 cycles → ack[2] one pulse, grant=0.
- Round-robin: req=4'b1011 held, each byte last=1 → grant order 0,1,3,0,1; pointer wraps after 3.
- Frame lock: req[1] sends 3 bytes 8'h10,8'h11,8'h12 with last on the third, req[0] also asserted throughout → all three bytes from 1 before any grant to 0; tx_start exactly 3 cycles after each tx_busy fall.
- Timeout: transmitter model never raises busy → err_timeout pulse 16 cycles after tx_start, no ack, grant cleared, next requester served.
- Early drop: req[3] deasserted during WAIT_DONE, last=0 → ack[3] still pulses, grant released at NEXT, no second tx_start.
- Reset mid-byte: rst_n low during WAIT_DONE → grant/tx_start/ack/err_timeout all 0 immediately; after release, fresh arbitration starts at requester 0.
